// File: rtl/six_bits_round_robin_encode_arbiter.sv
// 64-request round-robin arbiter: registered 6-bit winner index plus decoded one-hot,
// presented under a valid/ready handshake with no revocation once granted.
module six_bits_round_robin_encode_arbiter #(
    parameter int N_REQ = 64,
    parameter int SEL_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    input  logic             grant_ready,
    output logic             grant_valid,
    output logic [SEL_W-1:0] grant_index,
    output logic [N_REQ-1:0] grant_onehot
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           state, state_nxt;
    logic [SEL_W-1:0] ptr, ptr_nxt;
    logic [SEL_W-1:0] index_nxt;
    logic [SEL_W-1:0] search_start;
    logic [SEL_W-1:0] winner;
    logic             any_req;

    // Rotate the request vector so position 'start' lands at bit 0, then take the
    // lowest set bit; adding the offset back (mod 2^SEL_W) gives the circular winner.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] vec,
                                                 input logic [SEL_W-1:0] start);
        logic [2*N_REQ-1:0] dbl;
        logic [N_REQ-1:0]   rot;
        logic [SEL_W-1:0]   off;
        dbl = {vec, vec} >> start;
        rot = dbl[N_REQ-1:0];
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = SEL_W'(i);
        end
        return start + off;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            ptr         <= '0;
            grant_index <= '0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            grant_index <= index_nxt;
        end
    end

    // While a grant is showing, the next search starts just past it rather than at ptr,
    // so an acceptance can load the following winner in the same edge.
    always_comb begin
        any_req      = |req;
        search_start = (state == GRANT) ? grant_index + SEL_W'(1) : ptr;
        winner       = rr_pick(req, search_start);
        state_nxt    = state;
        ptr_nxt      = ptr;
        index_nxt    = grant_index;
        case (state)
            IDLE: begin
                if (any_req) begin
                    index_nxt = winner;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (grant_ready) begin
                    ptr_nxt = grant_index + SEL_W'(1);
                    if (any_req) index_nxt = winner;
                    else         state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign grant_valid  = (state == GRANT);
    assign grant_onehot = grant_valid ? (N_REQ'(1) << grant_index) : '0;

endmodule

// File: tb/tb_six_bits_round_robin_encode_arbiter.sv
// Scoreboard bench for the round-robin arbiter: a behavioural model pushes the expected
// outputs for each cycle as stimulus is driven; each scenario pops and compares after the edge.
module tb_six_bits_round_robin_encode_arbiter;

    logic        clk;
    logic        reset_n;
    logic [63:0] req;
    logic        grant_ready;
    logic        grant_valid;
    logic [5:0]  grant_index;
    logic [63:0] grant_onehot;

    six_bits_round_robin_encode_arbiter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (req),
        .grant_ready  (grant_ready),
        .grant_valid  (grant_valid),
        .grant_index  (grant_index),
        .grant_onehot (grant_onehot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [5:0]  idx;
        logic [63:0] oh;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   failures;

    logic [5:0] m_ptr;
    logic       m_valid;
    logic [5:0] m_idx;

    function automatic logic [5:0] scan(input logic [63:0] r, input logic [5:0] start);
        for (int k = 0; k < 64; k++) begin
            logic [5:0] j;
            j = start + 6'(k);
            if (r[j]) return j;
        end
        return start;
    endfunction

    task automatic model_reset();
        m_ptr   = '0;
        m_valid = 1'b0;
        m_idx   = '0;
        sb.delete();
    endtask

    task automatic drive_cycle(input logic [63:0] r, input logic rdy);
        exp_t e;
        req         = r;
        grant_ready = rdy;
        if (!m_valid) begin
            if (r != 64'd0) begin
                m_idx   = scan(r, m_ptr);
                m_valid = 1'b1;
            end
        end else if (rdy) begin
            m_ptr = m_idx + 6'd1;
            if (r != 64'd0) m_idx = scan(r, m_ptr);
            else            m_valid = 1'b0;
        end
        e.valid = m_valid;
        e.idx   = m_idx;
        e.oh    = m_valid ? (64'd1 << m_idx) : 64'd0;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req = '0;
        grant_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        reset_n = 1'b0;
        req = '0;
        grant_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (grant_valid !== 1'b0 || grant_index !== 6'd0 || grant_onehot !== 64'd0) begin
            failures++;
            $display("FAIL reset_init got v=%b i=%0d oh=%h want v=0 i=0 oh=0", grant_valid, grant_index, grant_onehot);
        end
        reset_n = 1'b1;
        drive_cycle({64{1'b1}}, 1'b0);
        e = sb.pop_front();
        checks++;
        if (grant_valid !== e.valid || grant_index !== e.idx || grant_onehot !== e.oh) begin
            failures++;
            $display("FAIL reset_first got v=%b i=%0d oh=%h want v=%b i=%0d oh=%h", grant_valid, grant_index, grant_onehot, e.valid, e.idx, e.oh);
        end
        // Asynchronous assertion mid-cycle with all requests still high.
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (grant_valid !== 1'b0 || grant_index !== 6'd0 || grant_onehot !== 64'd0) begin
            failures++;
            $display("FAIL reset_async got v=%b i=%0d oh=%h want v=0 i=0 oh=0", grant_valid, grant_index, grant_onehot);
        end
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        exp_t e;
        logic [63:0] r [4];
        logic [5:0]  want_idx [4];
        logic        want_v [4];
        r[0] = 64'd1 << 37;               want_v[0] = 1'b1; want_idx[0] = 6'd37;
        r[1] = 64'd0;                     want_v[1] = 1'b0; want_idx[1] = 6'd37;
        r[2] = (64'd1 << 40) | 64'd1;     want_v[2] = 1'b1; want_idx[2] = 6'd40;
        r[3] = 64'd0;                     want_v[3] = 1'b0; want_idx[3] = 6'd40;
        do_reset();
        for (int s = 0; s < 4; s++) begin
            drive_cycle(r[s], 1'b1);
            e = sb.pop_front();
            checks++;
            if (grant_valid !== e.valid || grant_index !== e.idx || grant_onehot !== e.oh ||
                grant_valid !== want_v[s] || grant_index !== want_idx[s]) begin
                failures++;
                $display("FAIL single step%0d got v=%b i=%0d oh=%h want v=%b i=%0d oh=%h", s, grant_valid, grant_index, grant_onehot, want_v[s], want_idx[s], e.oh);
            end
        end
    endtask

    task automatic test_rotation();
        exp_t e;
        do_reset();
        for (int s = 0; s < 66; s++) begin
            drive_cycle({64{1'b1}}, 1'b1);
            e = sb.pop_front();
            checks++;
            if (grant_valid !== 1'b1 || grant_index !== 6'(s % 64) || grant_onehot !== e.oh || grant_index !== e.idx) begin
                failures++;
                $display("FAIL rotation step%0d got v=%b i=%0d oh=%h want v=1 i=%0d oh=%h", s, grant_valid, grant_index, grant_onehot, s % 64, e.oh);
            end
        end
        drive_cycle(64'd0, 1'b1);
        e = sb.pop_front();
        checks++;
        if (grant_valid !== 1'b0 || grant_onehot !== 64'd0 || grant_index !== e.idx) begin
            failures++;
            $display("FAIL rotation_drain got v=%b i=%0d oh=%h want v=0 i=%0d oh=0", grant_valid, grant_index, grant_onehot, e.idx);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        logic [63:0] r;
        do_reset();
        // Ready while idle must not move the pointer.
        for (int s = 0; s < 3; s++) begin
            drive_cycle(64'd0, 1'b1);
            e = sb.pop_front();
        end
        drive_cycle((64'd1 << 5) | (64'd1 << 60), 1'b0);
        e = sb.pop_front();
        checks++;
        if (grant_valid !== 1'b1 || grant_index !== 6'd5 || grant_onehot !== e.oh) begin
            failures++;
            $display("FAIL bp_first got v=%b i=%0d oh=%h want v=1 i=5 oh=%h", grant_valid, grant_index, grant_onehot, e.oh);
        end
        for (int s = 0; s < 4; s++) begin
            r = (s == 0) ? ((64'd1 << 5) | (64'd1 << 60)) : (64'd1 << 60);
            drive_cycle(r, 1'b0);
            e = sb.pop_front();
            checks++;
            if (grant_valid !== 1'b1 || grant_index !== 6'd5 || grant_onehot !== (64'd1 << 5) || grant_index !== e.idx) begin
                failures++;
                $display("FAIL bp_hold%0d got v=%b i=%0d oh=%h want v=1 i=5", s, grant_valid, grant_index, grant_onehot);
            end
        end
        drive_cycle(64'd1 << 60, 1'b1);
        e = sb.pop_front();
        checks++;
        if (grant_valid !== 1'b1 || grant_index !== 6'd60 || grant_onehot !== e.oh || grant_index !== e.idx) begin
            failures++;
            $display("FAIL bp_release got v=%b i=%0d oh=%h want v=1 i=60 oh=%h", grant_valid, grant_index, grant_onehot, e.oh);
        end
        drive_cycle(64'd0, 1'b1);
        e = sb.pop_front();
    endtask

    task automatic test_wrap();
        exp_t e;
        logic [63:0] r [3];
        logic [5:0]  want_idx [3];
        r[0] = 64'd1 << 61;                   want_idx[0] = 6'd61;
        r[1] = (64'd1 << 3) | (64'd1 << 10);  want_idx[1] = 6'd3;
        r[2] = (64'd1 << 3) | (64'd1 << 10);  want_idx[2] = 6'd10;
        do_reset();
        for (int s = 0; s < 3; s++) begin
            drive_cycle(r[s], 1'b1);
            e = sb.pop_front();
            checks++;
            if (grant_valid !== 1'b1 || grant_index !== want_idx[s] || grant_index !== e.idx || grant_onehot !== e.oh) begin
                failures++;
                $display("FAIL wrap step%0d got v=%b i=%0d oh=%h want v=1 i=%0d oh=%h", s, grant_valid, grant_index, grant_onehot, want_idx[s], e.oh);
            end
        end
        drive_cycle(64'd0, 1'b1);
        e = sb.pop_front();
    endtask

    task automatic test_reset_mid_grant();
        exp_t e;
        logic [63:0] r;
        do_reset();
        drive_cycle(64'd1 << 20, 1'b0);
        e = sb.pop_front();
        drive_cycle(64'd1 << 20, 1'b1);
        e = sb.pop_front();
        drive_cycle(64'd1 << 20, 1'b0);
        e = sb.pop_front();
        checks++;
        if (grant_valid !== 1'b1 || grant_index !== 6'd20 || grant_onehot !== e.oh) begin
            failures++;
            $display("FAIL midrst_hold got v=%b i=%0d oh=%h want v=1 i=20 oh=%h", grant_valid, grant_index, grant_onehot, e.oh);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (grant_valid !== 1'b0 || grant_index !== 6'd0 || grant_onehot !== 64'd0) begin
            failures++;
            $display("FAIL midrst_async got v=%b i=%0d oh=%h want v=0 i=0 oh=0", grant_valid, grant_index, grant_onehot);
        end
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        r = (64'd1 << 1) | (64'd1 << 63);
        drive_cycle(r, 1'b1);
        e = sb.pop_front();
        checks++;
        if (grant_valid !== 1'b1 || grant_index !== 6'd1 || grant_index !== e.idx || grant_onehot !== e.oh) begin
            failures++;
            $display("FAIL midrst_first got v=%b i=%0d oh=%h want v=1 i=1 oh=%h", grant_valid, grant_index, grant_onehot, e.oh);
        end
        drive_cycle(r, 1'b1);
        e = sb.pop_front();
        checks++;
        if (grant_valid !== 1'b1 || grant_index !== 6'd63 || grant_index !== e.idx || grant_onehot !== e.oh) begin
            failures++;
            $display("FAIL midrst_second got v=%b i=%0d oh=%h want v=1 i=63 oh=%h", grant_valid, grant_index, grant_onehot, e.oh);
        end
    endtask

    task automatic test_random();
        exp_t e;
        logic [63:0] r;
        do_reset();
        for (int s = 0; s < 300; s++) begin
            case ($urandom_range(0, 3))
                0:       r = 64'd0;
                1:       r = 64'd1 << $urandom_range(0, 63);
                2:       r = (64'd1 << $urandom_range(0, 63)) | (64'd1 << $urandom_range(0, 63));
                default: r = {$urandom, $urandom};
            endcase
            drive_cycle(r, 1'($urandom_range(0, 1)));
            e = sb.pop_front();
            checks++;
            if (grant_valid !== e.valid || grant_index !== e.idx || grant_onehot !== e.oh) begin
                failures++;
                $display("FAIL random step%0d got v=%b i=%0d oh=%h want v=%b i=%0d oh=%h", s, grant_valid, grant_index, grant_onehot, e.valid, e.idx, e.oh);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset_n = 1'b0;
        req = '0;
        grant_ready = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_rotation();
        test_backpressure();
        test_wrap();
        test_reset_mid_grant();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
